// File: rtl/record_serializer_if.sv
// Handshake/bus bundle for record_serializer: record push side and word stream side.
// The overflow flag exists only when RECORD_SERIALIZER_OVERFLOW_EN is defined.
interface record_serializer_if #(
    parameter int unsigned WordSize    = 8,
    parameter int unsigned RecordWords = 16,
    parameter int unsigned Depth       = 4
);
    localparam int unsigned RecW = WordSize * RecordWords;
    localparam int unsigned SzW  = $clog2(Depth) + 1;

    logic                write_en;
    logic [RecW-1:0]     data_in;
    logic                out_ready;
    logic                out_valid;
    logic [WordSize-1:0] data_out;
    logic                full;
    logic                empty;
    logic                busy;
    logic [SzW-1:0]      size;
`ifdef RECORD_SERIALIZER_OVERFLOW_EN
    logic                overflow;

    modport master (
        output write_en, data_in, out_ready,
        input  out_valid, data_out, full, empty, busy, size, overflow
    );
    modport slave (
        input  write_en, data_in, out_ready,
        output out_valid, data_out, full, empty, busy, size, overflow
    );
`else
    modport master (
        output write_en, data_in, out_ready,
        input  out_valid, data_out, full, empty, busy, size
    );
    modport slave (
        input  write_en, data_in, out_ready,
        output out_valid, data_out, full, empty, busy, size
    );
`endif
endinterface

// File: rtl/record_serializer.sv
// Record queue feeding a shift stage that emits each record word 0 first over a valid/ready stream.
// Optional sticky overflow flag enabled by defining RECORD_SERIALIZER_OVERFLOW_EN.
module record_serializer #(
    parameter int unsigned WordSize    = 8,
    parameter int unsigned RecordWords = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic               clk,
    input  logic               rst,
    record_serializer_if.slave bus
);
    localparam int unsigned RecW  = WordSize * RecordWords;
    localparam int unsigned PtrW  = $clog2(Depth) + 1;
    localparam int unsigned QIdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned IdxW  = (RecordWords > 1) ? $clog2(RecordWords) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [IdxW-1:0]     idx;
    logic [RecW-1:0]     shift_reg;
    logic [WordSize-1:0] data_out_q;
    logic [RecW-1:0]     mem [Depth];

    logic [PtrW-1:0]     size_w;
    logic                full_w;
    logic                push;
    logic                xfer;
    logic                last;
    logic                load;
    logic [IdxW-1:0]     idx_nxt;
    logic [RecW-1:0]     rd_rec;

    assign size_w  = wr_ptr - rd_ptr;
    assign full_w  = (size_w == PtrW'(Depth));
    assign push    = bus.write_en && !full_w;
    assign xfer    = (state == SEND) && bus.out_ready;
    assign last    = (idx == IdxW'(RecordWords - 1));
    assign idx_nxt = idx + IdxW'(1);
    assign rd_rec  = mem[rd_ptr[QIdxW-1:0]];
    // Load from idle, or chain the next record on the last-word transfer with no bubble.
    assign load    = (size_w != '0) && ((state == IDLE) || (xfer && last));

    assign bus.size      = size_w;
    assign bus.full      = full_w;
    assign bus.empty     = (size_w == '0) && (state != SEND);
    assign bus.busy      = (state == SEND);
    assign bus.out_valid = (state == SEND);
    assign bus.data_out  = data_out_q;

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[QIdxW-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            shift_reg  <= '0;
            data_out_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (load) begin
                rd_ptr     <= rd_ptr + PtrW'(1);
                shift_reg  <= rd_rec;
                idx        <= '0;
                data_out_q <= rd_rec[WordSize-1:0];
                state      <= SEND;
            end else if (xfer) begin
                if (last) begin
                    state <= IDLE;
                end else begin
                    idx        <= idx_nxt;
                    data_out_q <= shift_reg[WordSize*int'(idx_nxt) +: WordSize];
                end
            end
        end
    end

`ifdef RECORD_SERIALIZER_OVERFLOW_EN
    logic overflow_q;

    // Sticky: any write attempt while full is remembered until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.write_en && full_w) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_record_serializer.sv
// Scoreboard bench for record_serializer: stimulus queues expected words, a negedge monitor checks them.
module tb_record_serializer;
    localparam int unsigned WordSize    = 8;
    localparam int unsigned RecordWords = 16;
    localparam int unsigned Depth       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    record_serializer_if #(.WordSize(WordSize), .RecordWords(RecordWords), .Depth(Depth)) bus ();

    record_serializer #(.WordSize(WordSize), .RecordWords(RecordWords), .Depth(Depth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [7:0] base, input bit expect_it);
        for (int k = 0; k < int'(RecordWords); k++) begin
            bus.data_in[k*8 +: 8] = base + 8'(k);
            if (expect_it) sb.push_back(base + 8'(k));
        end
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (!(bus.empty && sb.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(bus.empty && sb.size() == 0), 32'd1);
    endtask

    // Monitor: pops on every accepted word, and checks data_out holds while stalled.
    logic       stalled = 1'b0;
    logic [7:0] held    = '0;
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (stalled) check("stall_hold", 32'(bus.data_out), 32'(held));
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", bus.data_out);
                end else begin
                    check("word", 32'(bus.data_out), 32'(sb.pop_front()));
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = bus.data_out;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.write_en = 1'b0;
        bus.data_in  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_full",  32'(bus.full),      32'd0);
        check("rst_empty", 32'(bus.empty),     32'd1);
        check("rst_size",  32'(bus.size),      32'd0);
        check("rst_data",  32'(bus.data_out),  32'd0);
`ifdef RECORD_SERIALIZER_OVERFLOW_EN
        check("rst_ovf",   32'(bus.overflow),  32'd0);
`endif
        rst = 1'b0;
        tick();

        // Single record, consumer always ready: one-cycle latency then 16 words.
        bus.out_ready = 1'b1;
        push_rec(8'h00, 1'b1);
        check("lat_valid_n",   32'(bus.out_valid), 32'd0);
        check("lat_size_n",    32'(bus.size),      32'd1);
        tick();
        check("lat_valid_n1",  32'(bus.out_valid), 32'd1);
        check("lat_word0",     32'(bus.data_out),  32'h00);
        wait_drained("single_drain");

        // Fill the queue behind a stalled record, then overflow it.
        bus.out_ready = 1'b0;
        push_rec(8'h20, 1'b1);
        tick();
        check("fill_busy",  32'(bus.busy), 32'd1);
        check("fill_size0", 32'(bus.size), 32'd0);
        push_rec(8'h30, 1'b1);
        push_rec(8'h40, 1'b1);
        push_rec(8'h50, 1'b1);
        push_rec(8'h60, 1'b1);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_size", 32'(bus.size), 32'd4);
        push_rec(8'h70, 1'b0);
        check("drop_size", 32'(bus.size), 32'd4);
        check("drop_full", 32'(bus.full), 32'd1);
`ifdef RECORD_SERIALIZER_OVERFLOW_EN
        check("drop_ovf",  32'(bus.overflow), 32'd1);
`endif

        // Push into the full queue on the same edge the last word transfers.
        bus.out_ready = 1'b1;
        repeat (15) tick();
        check("last_busy", 32'(bus.busy), 32'd1);
        push_rec(8'h80, 1'b0);
        check("lastpush_size", 32'(bus.size), 32'd3);
        check("lastpush_full", 32'(bus.full), 32'd0);
`ifdef RECORD_SERIALIZER_OVERFLOW_EN
        check("lastpush_ovf",  32'(bus.overflow), 32'd1);
`endif
        wait_drained("fill_drain");

        // Two queued records stream 32 words with no gap.
        bus.out_ready = 1'b0;
        push_rec(8'h90, 1'b1);
        push_rec(8'hA0, 1'b1);
        check("two_size", 32'(bus.size), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("no_gap", 32'(bus.out_valid), 32'd1);
            tick();
        end
        check("two_empty", 32'(bus.empty), 32'd1);
        check("two_sb",    32'(sb.size()), 32'd0);

        // Alternating ready: every word once, held while stalled.
        push_rec(8'hB0, 1'b1);
        begin
            int n = 0;
            while (!(bus.empty && sb.size() == 0) && n < 100) begin
                bus.out_ready = ~bus.out_ready;
                tick();
                n++;
            end
        end
        check("toggle_drain", 32'(bus.empty && sb.size() == 0), 32'd1);

        // Reset mid-record with two records queued.
        bus.out_ready = 1'b0;
        push_rec(8'hC0, 1'b1);
        push_rec(8'hD0, 1'b0);
        push_rec(8'hE0, 1'b0);
        check("mid_size", 32'(bus.size), 32'd2);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("mid_remaining", 32'(sb.size()), 32'd11);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_size",  32'(bus.size),      32'd0);
        check("mid_rst_empty", 32'(bus.empty),     32'd1);
        check("mid_rst_data",  32'(bus.data_out),  32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (20) begin
            check("post_rst_idle", 32'(bus.out_valid), 32'd0);
            tick();
        end
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/record_serializer.md
RECORD_SERIALIZER -- requirements
Module: record_serializer

Interface
REQ-001 The block SHALL have parameter WordSize, default 8, giving the output word width in bits.
REQ-002 The block SHALL have parameter RecordWords, default 16, giving words per record; it SHALL be a power of 2.
REQ-003 The block SHALL have parameter Depth, default 4, giving the number of queued records; it SHALL be a power of 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port write_en, input, 1 bit: request to push data_in as one record.
REQ-007 The block SHALL have port data_in, input, WordSize*RecordWords bits: record to enqueue; word k occupies bits [(k+1)*WordSize-1 : k*WordSize].
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts data_out this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: data_out holds a valid word.
REQ-010 The block SHALL have port data_out, output, WordSize bits: current output word, registered.
REQ-011 The block SHALL have port full, output, 1 bit: the queue holds Depth records.
REQ-012 The block SHALL have port empty, output, 1 bit: the queue is empty and no record is being sent.
REQ-013 The block SHALL have port busy, output, 1 bit: a record is loaded in the shift stage.
REQ-014 The block SHALL have port size, output, $clog2(Depth)+1 bits: queued records, excluding the one in the shift stage.

Function
REQ-015 Queue SHALL use read/write record pointers one bit wider than the index; size = write_ptr - read_ptr modulo width; indexes wrap modulo Depth.
REQ-016 A push SHALL occur on an edge where write_en=1 and full=0: store data_in at write_ptr, increment write_ptr.
REQ-017 write_en while full=1 SHALL be dropped with no state change, even if a load pops on the same edge.
REQ-018 full SHALL equal (size==Depth); empty SHALL equal (size==0 && !busy); both combinational from registered state.
REQ-019 FSM states SHALL be IDLE and SEND; busy=1 exactly in SEND; out_valid=1 exactly in SEND.
REQ-020 IDLE with size>0 SHALL, on the next edge, load the record at read_ptr into the shift register, increment read_ptr, set word index 0, and enter SEND.
REQ-021 Word order SHALL be word 0 first, word RecordWords-1 last; data_out SHALL equal shift word[index].
REQ-022 In SEND, a transfer SHALL occur on an edge with out_valid=1 and out_ready=1; it SHALL increment index.
REQ-023 data_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 On transfer of the last word: if size>0, load the next record on the same edge with no bubble and stay in SEND; otherwise enter IDLE.
REQ-025 Latency: a push into an idle empty block at edge N SHALL yield out_valid=1 with word 0 after edge N+1.
REQ-026 A simultaneous push and load/pop SHALL leave size unchanged.

Reset
REQ-027 rst=1 SHALL immediately clear both pointers, the index, the shift register and data_out, and set the FSM to IDLE.
REQ-028 During reset, outputs SHALL be out_valid=0, busy=0, full=0, empty=1, size=0, data_out=0.
REQ-029 Reset mid-record SHALL discard that record and all queued records; remaining words are not emitted.

Configuration
REQ-030 With macro RECORD_SERIALIZER_OVERFLOW_EN defined, the block SHALL add output overflow, 1 bit. overflow SHALL be set sticky on any dropped write_en while full=1 and cleared only by rst.
REQ-031 Without RECORD_SERIALIZER_OVERFLOW_EN, the overflow port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Defaults. Push record words 0x00..0x0F with out_ready=1 held -> out_valid rises after edge N+1; data_out is 0x00..0x0F on 16 consecutive cycles; then empty=1.
REQ-033 Push 4 records back-to-back with out_ready=0 -> full=1 after the 4th push while a record sits in the shift stage. A 5th push is dropped: size stays at its value, and overflow=1 when RECORD_SERIALIZER_OVERFLOW_EN is defined.
REQ-034 Two queued records, out_ready=1 -> 32 consecutive valid words with no gap between word 15 and the next word 0.
REQ-035 Toggle out_ready 1/0 every cycle -> each word is emitted exactly once and data_out is stable while stalled.
REQ-036 Assert rst after 5 words are emitted with 2 records queued -> out_valid=0, size=0, empty=1 immediately; no further words are emitted after release.
REQ-037 Push into a full queue on the same edge the last word transfers -> the push is dropped and size decreases by 1.
